mcycle_exec_ctrl: RTL and testbench

//  Parametrised controller for NUNITS multi-cycle execute units (divider, clmul, FPU, ...).

---
 rtl/mcycle_exec_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mcycle_exec_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_exec_ctrl.sv
// Execute-stage controller for NUNITS multi-cycle units: issues one op at a time, stalls
// the pipeline until the unit answers, registers the result and drains or aborts hung ops.
module mcycle_exec_ctrl #(
  parameter int XLEN    = 32,
  parameter int NUNITS  = 3,
  parameter int TIMEOUT = 64,
  parameter int UW      = $clog2(NUNITS > 1 ? NUNITS : 2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic [UW-1:0]            issue_unit,
  input  logic [4:0]               issue_waddr,
  input  logic                     issue_fp,
  input  logic                     kill,
  input  logic                     hold,
  output logic [NUNITS-1:0]        unit_enable,
  input  logic [NUNITS-1:0]        unit_ready,
  input  logic [NUNITS*XLEN-1:0]   unit_result,
  output logic                     stall,
  output logic                     busy,
  output logic                     wb_valid,
  output logic                     wb_fp,
  output logic [4:0]               wb_waddr,
  output logic [XLEN-1:0]          wb_wdata,
  output logic                     wb_error
);

  localparam int CW = $clog2(TIMEOUT > 2 ? TIMEOUT : 2);
  localparam logic [UW:0] NU_L = (UW+1)'(NUNITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [UW-1:0]     r_unit;
  logic [4:0]        r_waddr;
  logic              r_fp;
  logic [CW-1:0]     r_cnt;
  logic              r_wb_valid;
  logic              r_wb_error;
  logic [XLEN-1:0]   r_wb_wdata;
  logic              w_accept;
  logic              w_legal;
  logic              w_rdy;
  logic              w_timeout;
  logic [XLEN-1:0]   w_res;
  logic              w_wb_err_nxt;
  logic [XLEN-1:0]   w_wb_data_nxt;

  // rst gates the combinational outputs so they drop to zero as soon as reset asserts
  assign w_accept  = rst & issue_valid & ~kill & ~hold &
                     ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_legal   = ({1'b0, issue_unit} < NU_L);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  assign unit_enable = (w_accept && w_legal) ? (NUNITS'(1) << issue_unit) : '0;
  assign busy        = (r_state != S_IDLE);
  assign wb_valid    = r_wb_valid;
  assign wb_error    = r_wb_error;
  assign wb_wdata    = r_wb_wdata;
  assign wb_waddr    = r_waddr;
  assign wb_fp       = r_fp;

  // Select ready/result of the unit owning the outstanding op
  always_comb begin
    w_rdy = 1'b0;
    w_res = '0;
    for (int i = 0; i < NUNITS; i++) begin
      w_rdy = (r_unit == UW'(i)) ? unit_ready[i] : w_rdy;
      w_res = (r_unit == UW'(i)) ? unit_result[i*XLEN +: XLEN] : w_res;
    end
  end

  // Stall request to the pipeline
  always_comb begin
    stall = 1'b0;
    case (r_state)
      S_IDLE:  stall = w_accept;
      S_DONE:  stall = w_accept;
      S_BUSY:  stall = rst;
      S_DRAIN: stall = rst & issue_valid;
      default: stall = 1'b0;
    endcase
  end

  // Next state and next writeback payload
  always_comb begin
    w_state_nxt   = r_state;
    w_wb_err_nxt  = r_wb_error;
    w_wb_data_nxt = r_wb_wdata;
    case (r_state)
      S_IDLE, S_DONE: begin
        if ((r_state == S_DONE) && kill) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept) begin
          if (w_legal) begin
            w_state_nxt = S_BUSY;
          end else begin
            w_state_nxt   = S_DONE;
            w_wb_err_nxt  = 1'b1;
            w_wb_data_nxt = '0;
          end
        end else if ((r_state == S_DONE) && !hold) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_BUSY: begin
        if (kill) begin
          w_state_nxt = w_rdy ? S_IDLE : S_DRAIN;
        end else if (w_rdy) begin
          w_state_nxt   = S_DONE;
          w_wb_err_nxt  = 1'b0;
          w_wb_data_nxt = w_res;
        end else if (w_timeout) begin
          w_state_nxt   = S_DONE;
          w_wb_err_nxt  = 1'b1;
          w_wb_data_nxt = '0;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DRAIN: begin
        if (w_rdy || w_timeout) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, captured op fields, watchdog counter and writeback registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_unit     <= '0;
      r_waddr    <= 5'd0;
      r_fp       <= 1'b0;
      r_cnt      <= '0;
      r_wb_valid <= 1'b0;
      r_wb_error <= 1'b0;
      r_wb_wdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wb_valid <= (w_state_nxt == S_DONE);
      r_wb_error <= (w_state_nxt == S_DONE) & w_wb_err_nxt;
      r_wb_wdata <= w_wb_data_nxt;
      if (w_accept) begin
        r_unit  <= issue_unit;
        r_waddr <= issue_waddr;
        r_fp    <= issue_fp;
        r_cnt   <= '0;
      end else if (((r_state == S_BUSY) || (r_state == S_DRAIN)) && (r_cnt != CNT_LAST)) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

endmodule

// File: tb/tb_mcycle_exec_ctrl.sv
// Bench for mcycle_exec_ctrl: directed scenarios plus random traffic, all checked against
// a transaction-level model of the outstanding op and the held writeback result.
module tb_mcycle_exec_ctrl;
  localparam int XLEN = 32;
  localparam int NU   = 3;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic [1:0]    issue_unit;
  logic [4:0]    issue_waddr;
  logic          issue_fp;
  logic          kill;
  logic          hold;
  logic [2:0]    unit_enable;
  logic [2:0]    unit_ready;
  logic [95:0]   unit_result;
  logic          stall;
  logic          busy;
  logic          wb_valid;
  logic          wb_fp;
  logic [4:0]    wb_waddr;
  logic [31:0]   wb_wdata;
  logic          wb_error;

  always #5 clk = ~clk;

  mcycle_exec_ctrl #(.XLEN(XLEN), .NUNITS(NU), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_unit(issue_unit),
    .issue_waddr(issue_waddr), .issue_fp(issue_fp), .kill(kill), .hold(hold),
    .unit_enable(unit_enable), .unit_ready(unit_ready), .unit_result(unit_result),
    .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_fp(wb_fp),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_error(wb_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an op outstanding at a unit (possibly killed) and/or a held result
  bit          m_pend, m_killed, m_res_ok, m_err, m_fp;
  int          m_wait;
  int          m_unit;
  logic [4:0]  m_waddr;
  logic [31:0] m_data;
  logic [95:0] g_res;
  int          s_stall, s_wbv, s_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_pend = 0; m_killed = 0; m_res_ok = 0; m_err = 0; m_fp = 0;
    m_wait = 0; m_unit = 0; m_waddr = 5'd0; m_data = 32'd0;
  endtask

  task automatic clr_cnt();
    s_stall = 0; s_wbv = 0; s_en = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic cyc(input logic iv, input logic [1:0] iu, input logic [4:0] wa,
                     input logic f, input logic k, input logic h, input logic [2:0] rdy);
    bit         acc, leg, rdy_u, tmo;
    logic [2:0] en_exp;
    @(negedge clk);
    issue_valid = iv; issue_unit = iu; issue_waddr = wa; issue_fp = f;
    kill = k; hold = h; unit_ready = rdy; unit_result = g_res;
    #1;
    acc    = iv && !k && !h && !m_pend;
    leg    = (int'(iu) < NU);
    en_exp = 3'b000;
    if (acc && leg) en_exp[iu] = 1'b1;
    chk("unit_enable", {29'd0, unit_enable}, {29'd0, en_exp});
    chk("stall", {31'd0, stall}, {31'd0, acc || (m_pend && (!m_killed || iv))});
    chk("busy", {31'd0, busy}, {31'd0, m_pend || m_res_ok});
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_res_ok});
    if (m_res_ok) begin
      chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, m_waddr});
      chk("wb_fp", {31'd0, wb_fp}, {31'd0, m_fp});
      chk("wb_wdata", wb_wdata, m_data);
      chk("wb_error", {31'd0, wb_error}, {31'd0, m_err});
    end
    s_stall += int'(stall);
    s_wbv   += int'(wb_valid);
    if (unit_enable != 3'b000) s_en++;

    rdy_u = m_pend && rdy[m_unit];
    tmo   = m_pend && !rdy_u && (m_wait >= TO - 1);
    if (m_pend) begin
      if (m_wait < TO - 1) m_wait++;
      if (!m_killed) begin
        if (k) begin
          if (rdy_u) m_pend = 0;
          else m_killed = 1;
        end else if (rdy_u) begin
          m_pend = 0; m_res_ok = 1; m_err = 0; m_data = g_res[m_unit*32 +: 32];
        end else if (tmo) begin
          m_pend = 0; m_res_ok = 1; m_err = 1; m_data = 32'd0;
        end
      end else if (rdy_u || tmo) begin
        m_pend = 0; m_killed = 0;
      end
    end else if (m_res_ok && k) begin
      m_res_ok = 0;
    end else if (acc) begin
      m_res_ok = 0; m_waddr = wa; m_fp = f; m_unit = int'(iu);
      if (leg) begin
        m_pend = 1; m_killed = 0; m_wait = 0;
      end else begin
        m_res_ok = 1; m_err = 1; m_data = 32'd0;
      end
    end else if (m_res_ok && !h) begin
      m_res_ok = 0;
    end
    @(posedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_enable"}, {29'd0, unit_enable}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wb_error"}, {31'd0, wb_error}, 32'd0);
    chk({tag, "_wb_wdata"}, wb_wdata, 32'd0);
    chk({tag, "_wb_waddr"}, {27'd0, wb_waddr}, 32'd0);
    chk({tag, "_wb_fp"}, {31'd0, wb_fp}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; issue_valid = 1'b0; issue_unit = 2'd0; issue_waddr = 5'd0; issue_fp = 1'b0;
    kill = 1'b0; hold = 1'b0; unit_ready = 3'b000; unit_result = 96'd0; g_res = 96'd0;
    model_clear(); clr_cnt();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); rst = 1'b1;

    // Unit 1, ready four cycles after issue
    g_res = {32'h0, 32'hDEADBEEF, 32'h0};
    clr_cnt();
    cyc(1, 2'd1, 5'd5, 0, 0, 0, 3'b000);
    repeat (3) cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b010);
    repeat (2) cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    chk("t1_stall_cycles", s_stall, 5);
    chk("t1_wb_cycles", s_wbv, 1);
    chk("t1_enable_cycles", s_en, 1);

    // Result held for three cycles
    g_res = {64'h0, 32'hCAFEF00D};
    cyc(1, 2'd0, 5'd7, 1, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 1, 3'b001);
    clr_cnt();
    repeat (3) cyc(0, 2'd0, 5'd0, 0, 0, 1, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    chk("t2_wb_cycles", s_wbv, 4);
    chk("t2_stall_cycles", s_stall, 0);

    // Kill two cycles after issue, drain, blocked issue accepted once drained
    clr_cnt();
    cyc(1, 2'd0, 5'd9, 0, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 1, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    chk("t3_en_before", s_en, 1);
    clr_cnt();
    cyc(1, 2'd1, 5'd10, 0, 0, 0, 3'b000);
    cyc(1, 2'd1, 5'd10, 0, 0, 0, 3'b000);
    cyc(1, 2'd1, 5'd10, 0, 0, 0, 3'b001);
    chk("t3_drain_stall", s_stall, 3);
    chk("t3_drain_wb", s_wbv, 0);
    chk("t3_drain_en", s_en, 0);
    g_res = {32'h0, 32'h12345678, 32'h0};
    cyc(1, 2'd1, 5'd10, 0, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b010);
    repeat (2) cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);

    // Back-to-back: new issue in the writeback cycle
    clr_cnt();
    g_res = {32'hA5A5A5A5, 32'h0, 32'h11111111};
    cyc(1, 2'd0, 5'd11, 0, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b001);
    cyc(1, 2'd2, 5'd12, 1, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b100);
    repeat (2) cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    chk("t4_enables", s_en, 2);
    chk("t4_wb_cycles", s_wbv, 2);

    // Watchdog abort on a unit that never answers; later stray ready ignored
    cyc(1, 2'd2, 5'd3, 0, 0, 0, 3'b000);
    clr_cnt();
    repeat (TO) cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    chk("t5_busy_stall", s_stall, TO);
    chk("t5_wb_before", s_wbv, 0);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b100);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    chk("t5_wb_after", s_wbv, 1);

    // Illegal unit index
    clr_cnt();
    cyc(1, 2'd3, 5'd4, 1, 0, 0, 3'b111);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    chk("t6_no_enable", s_en, 0);
    chk("t6_wb_cycles", s_wbv, 1);

    // Killed op whose unit never answers drains out silently
    cyc(1, 2'd1, 5'd2, 0, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 1, 0, 3'b000);
    repeat (TO + 2) cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);

    // Asynchronous reset while busy
    cyc(1, 2'd2, 5'd6, 0, 0, 0, 3'b000);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);
    @(negedge clk);
    issue_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_clear();
    @(negedge clk);
    rst = 1'b1; issue_valid = 1'b0;
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b100);
    cyc(0, 2'd0, 5'd0, 0, 0, 0, 3'b000);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      g_res = {$urandom(), $urandom(), $urandom()};
      cyc(($urandom_range(0, 1) == 1), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 4) == 0),
          {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
